// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game controller: state codes, playfield
// geometry and default timing/lives.
package breakout_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SERVE   = 3'd1;
  localparam state_t ST_PLAY    = 3'd2;
  localparam state_t ST_NEWBALL = 3'd3;
  localparam state_t ST_CLEARED = 3'd4;
  localparam state_t ST_OVER    = 3'd5;

  localparam int ROW_BRICKS  = 6;
  localparam int COL_BRICKS  = 8;
  localparam int NUM_BRICKS  = ROW_BRICKS * COL_BRICKS;
  localparam int DELAY_TICKS = 120;
  localparam int INIT_LIVES  = 3;

  localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed-BCD counter with synchronous clear, increment enable and
// saturation at 9999.
module bcd_counter4
  import breakout_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;
  logic        carry;
  logic [3:0]  digit;

  always_comb begin
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    count_d = count_q;
    carry   = 1'b1;
    digit   = '0;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != SCORE_MAX)) begin
      // Ripple a +1 carry through the digits, wrapping 9 -> 0.
      for (int i = 0; i < 4; i++) begin
        digit = count_q[4*i +: 4];
        if (carry) begin
          if (digit == 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = digit + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: serve/new-ball/cleared pauses, brick scoreboard,
// BCD score, lives and level tracking.
module breakout_game_ctrl #(
  parameter int NUM_BRICKS  = breakout_pkg::NUM_BRICKS,
  parameter int DELAY_TICKS = breakout_pkg::DELAY_TICKS,
  parameter int INIT_LIVES  = breakout_pkg::INIT_LIVES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  refr_tick,
  input  logic                  miss,
  input  logic                  brk_hit,
  input  logic [5:0]            brk_idx,
  output logic                  gra_still,
  output logic [NUM_BRICKS-1:0] bricks_alive,
  output logic [15:0]           score,
  output logic [1:0]            lives,
  output logic [3:0]            level,
  output logic [2:0]            game_state
);

  import breakout_pkg::*;

  localparam int TW = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [1:0]            lives_q, lives_d;
  logic [3:0]            level_q, level_d;
  logic [NUM_BRICKS-1:0] bricks_alive_q, bricks_alive_d;
  logic                  score_clr, score_inc;
  logic                  idx_ok, hit_ok;

  assign idx_ok = (int'(brk_idx) < NUM_BRICKS);
  assign hit_ok = (state_q == ST_PLAY) && brk_hit && idx_ok && bricks_alive_q[brk_idx];

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    lives_d        = lives_q;
    level_d        = level_q;
    bricks_alive_d = bricks_alive_q;
    score_clr      = 1'b0;
    score_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_SERVE;
          lives_d        = 2'(INIT_LIVES);
          level_d        = 4'd1;
          bricks_alive_d = '1;
          score_clr      = 1'b1;
        end
      end
      ST_SERVE, ST_NEWBALL, ST_CLEARED: begin
        if (refr_tick) begin
          if (timer_q == TW'(DELAY_TICKS - 1)) begin
            state_d = ST_PLAY;
            if (state_q == ST_CLEARED) begin
              bricks_alive_d = '1;
              if (level_q != 4'd15) level_d = level_q + 4'd1;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      ST_PLAY: begin
        if (hit_ok) begin
          bricks_alive_d[brk_idx] = 1'b0;
          score_inc               = 1'b1;
        end
        // A miss outranks clearing the board in the same cycle.
        if (miss) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = ST_NEWBALL;
          end else begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end
        end else if (hit_ok && (bricks_alive_d == '0)) begin
          state_d = ST_CLEARED;
        end
      end
      ST_OVER: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      lives_q        <= '0;
      level_q        <= '0;
      bricks_alive_q <= '1;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      bricks_alive_q <= bricks_alive_d;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .count (score)
  );

  assign gra_still    = (state_q != ST_PLAY);
  assign bricks_alive = bricks_alive_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign game_state   = state_q;

endmodule

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 Parameter NUM_BRICKS, default 48, number of bricks in the scoreboard (6 rows x 8 columns).
REQ-002 Parameter DELAY_TICKS, default 120, refresh ticks spent in each timed pause (2 s at 60 Hz).
REQ-003 Parameter INIT_LIVES, default 3, lives loaded at game start.
REQ-004 clk  input  1  system clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse, any button pressed.
REQ-007 refr_tick  input  1  single-cycle pulse at start of vertical sync.
REQ-008 miss  input  1  single-cycle pulse, ball passed the paddle.
REQ-009 brk_hit  input  1  single-cycle pulse, ball collided with brick brk_idx.
REQ-010 brk_idx  input  6  index of the collided brick, row-major, valid with brk_hit.
REQ-011 gra_still  output  1  freeze ball and paddle at their initial positions.
REQ-012 bricks_alive  output  NUM_BRICKS  bit i high means brick i is drawn and collidable.
REQ-013 score  output  16  four BCD digits, digit 0 in bits 3:0.
REQ-014 lives  output  2  remaining balls.
REQ-015 level  output  4  current level, binary, starting at 1.
REQ-016 game_state  output  3  state code used for text-overlay selection.

Function
REQ-017 States: IDLE, SERVE, PLAY, NEWBALL, CLEARED, OVER, with fixed encodings 0..5 driven on game_state.
REQ-018 gra_still shall be 1 in every state except PLAY; it shall be decoded from the state register only, with no combinational input-to-output path.
REQ-019 IDLE + start -> SERVE; the same edge loads lives=INIT_LIVES, score=0, level=1, bricks_alive=all ones, and timer=0.
REQ-020 SERVE, NEWBALL, CLEARED: the timer increments on refr_tick; on the refr_tick where the timer equals DELAY_TICKS-1, the block goes to PLAY and clears the timer.
REQ-021 CLEARED exit additionally sets bricks_alive to all ones and increments level, saturating at 15.
REQ-022 PLAY + brk_hit with brk_idx<NUM_BRICKS and bricks_alive[brk_idx]=1 -> clear that bit and add 1 (BCD) to score next cycle; score saturates at 9999.
REQ-023 brk_hit for an already-cleared brick, an index >= NUM_BRICKS, or any state other than PLAY shall be ignored.
REQ-024 If the accepted hit clears the last alive brick and miss=0 in the same cycle, the block goes PLAY -> CLEARED.
REQ-025 PLAY + miss with lives>1: decrement lives and go to NEWBALL.
REQ-026 PLAY + miss with lives=1: set lives=0 and go to OVER.
REQ-027 Simultaneous miss and accepted brk_hit: apply the brick clear and score update, then take the miss transition (miss has priority over CLEARED).
REQ-028 OVER + start -> IDLE; all other inputs are ignored in OVER, and score and level hold for display.
REQ-029 start is ignored in SERVE, PLAY, NEWBALL and CLEARED; miss is ignored outside PLAY.
REQ-030 Timer width: ceil(log2(DELAY_TICKS)) bits; it is cleared on every state entry.

Reset
REQ-031 Asynchronous reset forces state=IDLE, timer=0, score=0, lives=0, level=0, and bricks_alive=all ones.
REQ-032 Reset asserted mid-pause or mid-play aborts immediately; outputs take their reset values while reset is high, and gra_still=1.

Structure
REQ-033 Shared package breakout_pkg holds: state encoding typedef, NUM_BRICKS, ROW_BRICKS=6, COL_BRICKS=8, default DELAY_TICKS, and INIT_LIVES.
REQ-034 Score arithmetic is one sub-module, bcd_counter4: synchronous clear, increment enable, saturation at 9999; it is instantiated once.

Verification
REQ-035 Reset, then start -> SERVE with gra_still=1, lives=3, score=0000, level=1, bricks_alive=all ones; after 120 refr_ticks -> PLAY, gra_still=0.
REQ-036 In PLAY, brk_hit idx=5 twice -> bricks_alive[5]=0 and score=0001 (second hit ignored); brk_hit idx=50 -> no change.
REQ-037 In PLAY, score=0009 plus one accepted hit -> score=0010; score forced to 9999 plus one hit -> stays 9999.
REQ-038 Three misses, each after returning to PLAY -> NEWBALL, NEWBALL, then OVER with lives=0; start -> IDLE.
REQ-039 Last alive brick hit alone -> CLEARED, then after 120 ticks bricks all ones and level=2; last brick hit plus miss in the same cycle -> NEWBALL, brick cleared, score incremented.
REQ-040 Reset asserted in NEWBALL at tick 60 -> IDLE, timer=0, and all outputs at their reset values on the same cycle.
